// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, arbiter FSM states and the legal-op check shared by the arbiter slice.
package alu_pkg;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
    endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester-side request/response channels of the shared-ALU arbiter.
interface alu_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [4*NUM_REQ-1:0]  req_op;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [31:0]           rsp_result;
    logic                  rsp_zero;
    logic                  rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// rr_pick: round-robin picker, first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_pick #(parameter int NUM_REQ = 4) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int W = $clog2(NUM_REQ);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_REQ]) idx = W'((int'(ptr) + i) % NUM_REQ);
        end
        any = |req;
        grant = any ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU with registered operands and response.
// Define ALU_ARB_ILLEGAL_OP_EN to answer illegal opcodes directly with rsp_err instead of using the ALU.
module alu_arbiter import alu_pkg::*; #(parameter int NUM_REQ = 4) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus,
    output logic [31:0]  alu_data1,
    output logic [31:0]  alu_read2,
    output logic [3:0]   alu_ALUcontrol,
    input  logic [31:0]  alu_ALUresult,
    input  logic         alu_zero
);
    localparam int W = $clog2(NUM_REQ);

    state_t               state, state_n;
    logic [W-1:0]         rr_ptr, g, idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 any, ill, accept, zero, err;
    logic [3:0]           op;
    logic [31:0]          a, b, res;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (.req(bus.req_valid), .ptr(rr_ptr), .grant(grant), .idx(idx), .any(any));

`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign ill = !is_legal_op(bus.req_op[4*idx +: 4]);
`else
    assign ill = 1'b0;
`endif

    always_comb begin
        accept = state == IDLE && any;
        state_n = state == IDLE ? (any ? (ill ? RESP : EXEC) : IDLE)
                : state == EXEC ? RESP
                : (bus.rsp_ready[g] ? IDLE : RESP);
        bus.req_ready = accept ? grant : '0;
        bus.rsp_valid = state == RESP ? NUM_REQ'(1) << g : '0;
        alu_data1 = state == EXEC ? a : '0;
        alu_read2 = state == EXEC ? b : '0;
        alu_ALUcontrol = state == EXEC ? op : '0;
    end

    assign bus.rsp_result = res;
    assign bus.rsp_zero = zero;
    assign bus.rsp_err = err;

    // Illegal ops preload the canned error response at accept since they bypass EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            g <= '0;
            op <= '0;
            a <= '0;
            b <= '0;
            res <= '0;
            zero <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                g <= idx;
                op <= bus.req_op[4*idx +: 4];
                a <= bus.req_a[32*idx +: 32];
                b <= bus.req_b[32*idx +: 32];
                res <= '0;
                zero <= ill;
                err <= ill;
            end
            if (state == EXEC) begin
                res <= alu_ALUresult;
                zero <= alu_zero;
            end
            if (state == RESP && bus.rsp_ready[g]) rr_ptr <= g == W'(NUM_REQ - 1) ? '0 : g + 1'b1;
        end
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequenced round-robin arbiter that shares the single combinational ALU between up to NUM_REQ requesters (e.g. main datapath, branch-compare unit, address generator). Accepts one operation per grant and drives the ALU from registered operands for one cycle. It captures result and zero flag, then returns them to the winning requester over a valid/ready response channel. Sits between the requesters and the ALU instance; the ALU's ALUSrc is tied 0 and instruction is tied 0, so the arbiter always supplies both operands explicitly.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  one-hot; operands accepted this cycle
- req_op  in  4*NUM_REQ  ALU control code, requester i at [4i+3:4i]
- req_a  in  32*NUM_REQ  operand A, requester i at [32i+31:32i]
- req_b  in  32*NUM_REQ  operand B, same packing
- rsp_valid  out  NUM_REQ  one-hot; response for requester i valid
- rsp_ready  in  NUM_REQ  requester i consumes response
- rsp_result  out  32  captured ALUresult
- rsp_zero  out  1  captured zero flag
- rsp_err  out  1  illegal opcode (see Configuration)
- alu_data1  out  32  to ALU data1
- alu_read2  out  32  to ALU read2
- alu_ALUcontrol  out  4  to ALU ALUcontrol
- alu_ALUresult  in  32  from ALU
- alu_zero  in  1  from ALU

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, pick winner g = first set bit at or above rr_ptr, wrapping modulo NUM_REQ. Assert req_ready[g] combinationally that cycle and latch req_op/req_a/req_b of g plus g. Next state is EXEC. With no valid requests, stay in IDLE.
- EXEC: drive latched operands and op to the ALU. At the clock edge ending EXEC, capture alu_ALUresult and alu_zero into rsp registers. Next state is RESP.
- RESP: rsp_valid[g]=1, and rsp_result, rsp_zero and rsp_err are held stable. When rsp_ready[g]=1, clear rsp_valid, set rr_ptr=(g+1) mod NUM_REQ and go to IDLE. rsp_ready bits of non-winners are ignored.
- req_ready is only ever asserted in IDLE; no new request is accepted while EXEC or RESP is in progress.
- ALU outputs when not in EXEC: alu_data1, alu_read2 and alu_ALUcontrol are 0 (AND of zeros; keeps the ALU quiet).
- Legal ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR. The arbiter does no arithmetic itself; all results come from the ALU.

## Timing
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, all alu_* outputs 0.
- Latency from accept cycle (req_valid&req_ready) to rsp_valid: exactly 2 cycles.
- Max throughput: one op per 3 cycles with rsp_ready held high.
- A requester may drop req_valid before it is granted; nothing is latched for it.
- Simultaneous requests: arbitration is round-robin. A requester that keeps req_valid high is granted within NUM_REQ grants.
- A response for a requester whose rsp_ready is low stalls the arbiter indefinitely. This is intended; there is no timeout.
- Reset asserted mid-operation: in-flight op and pending response are discarded next edge, and all outputs return to reset values.

## Configuration
- ALU_ARB_ILLEGAL_OP_EN defined: on accept, an op outside the legal set skips EXEC. The FSM goes IDLE→RESP directly, and latency is 1 cycle. It returns rsp_err=1, rsp_result=0 and rsp_zero=1. ALU outputs stay 0.
- ALU_ARB_ILLEGAL_OP_EN undefined: all ops are forwarded to the ALU through EXEC, and rsp_err is constant 0.

## Structure
- Shared package alu_pkg: ALU op code constants (AND/OR/ADD/SUB/SLT/NOR), FSM state encoding, and an is_legal_op function.
- One sub-module: rr_pick (NUM_REQ-wide round-robin picker). Inputs are the request vector and pointer; outputs are the one-hot grant and binary index.

## Test plan
- Single request: req 0 ADD a=5 b=7 → req_ready[0] on accept cycle; 2 cycles later rsp_valid[0]=1, result=12, zero=0.
- SUB equal operands: req 2 op 0110 a=b=0x1234 → result 0, zero=1.
- All four valid continuously with rsp_ready=all 1s → grant order 0,1,2,3,0 and one response every 3 cycles.
- Backpressure: rsp_ready[1]=0 for 5 cycles during req 1 OR 0xF0|0x0F → rsp_valid[1] and result 0xFF held stable. No req_ready is asserted until release.
- Reset asserted in EXEC → next cycle all outputs 0, state IDLE, and rr_ptr=0; the dropped op never responds.
- Macro defined, op 0011 → rsp_err=1, result 0, zero=1, rsp_valid 1 cycle after accept. Macro undefined → rsp_err=0 and the response arrives 2 cycles after accept.
